// File: rtl/awgn_pkg.sv
// Shared sizing constants and FSM state type for the AWGN u0 front end.
package awgn_pkg;

    // Sample width, matching shifteru0
    localparam int AWGN_W     = 48;
    // Exponent width; 2**AWGN_EW must exceed AWGN_W
    localparam int AWGN_EW    = 6;
    // Default number of bits examined per scan cycle
    localparam int AWGN_CHUNK = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/shifteru0.sv
// Left shifter used to strip the leading one from the uniform sample u0.
// Shifting by the full width yields zero.
module shifteru0 #(
    parameter int W  = 48,
    parameter int EW = 6
) (
    input  logic [W-1:0]  u0,
    input  logic [EW-1:0] exp_e,
    output logic [W-1:0]  x_e
);

    // Logical shift; amounts >= W flush the word to zero
    always_comb begin
        x_e = u0 << exp_e;
    end

endmodule

// File: rtl/u0_chunk_lzc.sv
// Combinational leading-zero count of one CHUNK-bit slice of u0.
// lz equals CHUNK when the slice is all-zero; nz flags a set bit.
module u0_chunk_lzc #(
    parameter int CHUNK = 8,
    parameter int LZW   = $clog2(CHUNK + 1)
) (
    input  logic [CHUNK-1:0] chunk,
    output logic [LZW-1:0]   lz,
    output logic             nz
);

    // Scan LSB to MSB so the highest set bit wins the last assignment
    always_comb begin
        lz = LZW'(CHUNK);
        nz = |chunk;
        for (int i = 0; i < CHUNK; i++) begin
            if (chunk[i]) begin
                lz = LZW'(CHUNK - 1 - i);
            end
        end
    end

endmodule

// File: rtl/u0_norm_seq.sv
// Normalising sequencer for u0: finds the leading-zero count with an
// MSB-first chunk scan, then shifts the leading one out via shifteru0.
// Result {x_e, exp_e, u0_zero} is held until downstream accepts it.
module u0_norm_seq
    import awgn_pkg::*;
#(
    parameter int W     = AWGN_W,
    parameter int CHUNK = AWGN_CHUNK,
    parameter int EW    = AWGN_EW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          u0_valid,
    output logic          u0_ready,
    input  logic [W-1:0]  u0,
    output logic          x_valid,
    input  logic          x_ready,
    output logic [W-1:0]  x_e,
    output logic [EW-1:0] exp_e,
    output logic          u0_zero,
    output logic          busy
);

    localparam int NCH = W / CHUNK;
    localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int LZW = $clog2(CHUNK + 1);

    state_t             state;
    logic [W-1:0]       u0_held;
    logic [KW-1:0]      k;
    logic [CHUNK-1:0]   chunk;
    logic [LZW-1:0]     chunk_lz;
    logic               chunk_nz;
    logic               last_chunk;
    logic [W-1:0]       shift_out;

    // Exponent for a hit in chunk kk: bits skipped so far plus the in-chunk
    // zeros, plus one more so the shift also drops the leading one.
    function automatic logic [EW-1:0] exp_from_chunk(input logic [KW-1:0]  kk,
                                                     input logic [LZW-1:0] lz);
        return EW'(int'(kk) * CHUNK + int'(lz) + 1);
    endfunction

    // Select chunk k of the held sample, MSB-first
    always_comb begin
        chunk = '0;
        for (int i = 0; i < NCH; i++) begin
            if (k == KW'(i)) begin
                chunk = u0_held[W-1-i*CHUNK -: CHUNK];
            end
        end
    end

    assign last_chunk = (k == KW'(NCH - 1));
    assign u0_ready   = (state == IDLE);
    assign busy       = (state != IDLE);

    u0_chunk_lzc #(
        .CHUNK (CHUNK),
        .LZW   (LZW)
    ) u_lzc (
        .chunk (chunk),
        .lz    (chunk_lz),
        .nz    (chunk_nz)
    );

    shifteru0 #(
        .W  (W),
        .EW (EW)
    ) u_shift (
        .u0    (u0_held),
        .exp_e (exp_e),
        .x_e   (shift_out)
    );

    // Sequencer: capture, scan, shift, then hold the result until taken
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            u0_held <= '0;
            k       <= '0;
            exp_e   <= '0;
            x_e     <= '0;
            u0_zero <= 1'b0;
            x_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (u0_valid) begin
                        u0_held <= u0;
                        k       <= '0;
                        state   <= SCAN;
                    end
                end
                SCAN: begin
                    if (chunk_nz) begin
                        exp_e   <= exp_from_chunk(k, chunk_lz);
                        u0_zero <= 1'b0;
                        state   <= SHIFT;
                    end else if (last_chunk) begin
                        exp_e   <= EW'(W);
                        u0_zero <= 1'b1;
                        state   <= SHIFT;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                SHIFT: begin
                    x_e     <= shift_out;
                    x_valid <= 1'b1;
                    state   <= DONE;
                end
                DONE: begin
                    if (x_ready) begin
                        x_valid <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
